parallel_operand_loader: RTL and testbench

//   Upstream stage of the parallel vector unit. Receives operand bytes serially over a

---
 rtl/parallel_operand_loader.sv | 94 +++++++++
 tb/tb_parallel_operand_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_operand_loader.sv
// Serial-to-parallel operand loader: assembles 24 stream bytes into six 4-lane
// operand vectors and presents the complete set with a valid/ready handshake.
module parallel_operand_loader #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int VECTORS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    output logic                    s_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] a_vec,
    output logic [LANES*DATA_W-1:0] b_vec,
    output logic [LANES*DATA_W-1:0] c_vec,
    output logic [LANES*DATA_W-1:0] d_vec,
    output logic [LANES*DATA_W-1:0] e_vec,
    output logic [LANES*DATA_W-1:0] f_vec,
    output logic [4:0]              fill_count
);

    localparam int VEC_W = LANES * DATA_W;
    localparam int TOTAL = LANES * VECTORS;
    localparam int SET_W = TOTAL * DATA_W;

    localparam logic [0:0] ST_FILL    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;
    localparam logic [4:0] LAST_IDX   = 5'(TOTAL - 1);

    logic [0:0]       state_q, state_d;
    logic [4:0]       count_q, count_d;
    logic [SET_W-1:0] vec_q,   vec_d;

    // Byte n of a set lives at bits [n*DATA_W +: DATA_W], which places it in
    // vector n/LANES, lane n%LANES with lane 1 in the least significant byte.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        vec_d   = vec_q;
        if (clear) begin
            state_d = ST_FILL;
            count_d = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (s_valid) begin
                        vec_d[int'(count_q) * DATA_W +: DATA_W] = s_data;
                        count_d = count_q + 5'd1;
                        if (count_q == LAST_IDX) state_d = ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        state_d = ST_FILL;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the vector storage is reset too because outputs must read zero after reset.
        if (!rst_n) begin
            state_q <= ST_FILL;
            count_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            vec_q   <= vec_d;
        end
    end

    assign s_ready    = (state_q == ST_FILL);
    assign out_valid  = (state_q == ST_PRESENT);
    assign fill_count = count_q;

    assign a_vec = vec_q[0*VEC_W +: VEC_W];
    assign b_vec = vec_q[1*VEC_W +: VEC_W];
    assign c_vec = vec_q[2*VEC_W +: VEC_W];
    assign d_vec = vec_q[3*VEC_W +: VEC_W];
    assign e_vec = vec_q[4*VEC_W +: VEC_W];
    assign f_vec = vec_q[5*VEC_W +: VEC_W];

endmodule

// File: tb/tb_parallel_operand_loader.sv
// Scoreboard bench for parallel_operand_loader: stimulus pushes expected operand
// sets built from the byte-order rule; a monitor checks each presented set.
module tb_parallel_operand_loader;

    typedef logic [5:0][31:0] set_t;  // index 0 = a_vec ... 5 = f_vec

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] a_vec, b_vec, c_vec, d_vec, e_vec, f_vec;
    logic [4:0]  fill_count;

    int n_cmp = 0;
    int n_bad = 0;

    set_t       sb_q[$];
    logic [7:0] cur[$];

    parallel_operand_loader dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_vec(a_vec), .b_vec(b_vec), .c_vec(c_vec),
        .d_vec(d_vec), .e_vec(e_vec), .f_vec(f_vec),
        .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic set_t dut_set();
        set_t s;
        s[0] = a_vec; s[1] = b_vec; s[2] = c_vec;
        s[3] = d_vec; s[4] = e_vec; s[5] = f_vec;
        return s;
    endfunction

    // Reference: byte n of a set goes to vector n/4, lane (n%4)+1 (bits 8k-1:8k-8).
    function automatic set_t model_set(input logic [7:0] bytes[$]);
        set_t s = '0;
        for (int n = 0; n < 24; n++) begin
            int v = n / 4;
            int lane = (n % 4) + 1;
            s[v][8*lane-1 -: 8] = bytes[n];
        end
        return s;
    endfunction

    // Monitor: pops an expected set on each new presentation and checks it stays stable.
    bit   seen = 1'b0;
    set_t held;
    always @(negedge clk) begin
        if (out_valid) begin
            if (!seen) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                    held = dut_set();
                end else begin
                    held = sb_q.pop_front();
                    for (int v = 0; v < 6; v++)
                        check($sformatf("set_vec%0d", v), dut_set()[v], held[v]);
                end
                seen = 1'b1;
            end else begin
                for (int v = 0; v < 6; v++)
                    check($sformatf("hold_vec%0d", v), dut_set()[v], held[v]);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input bit gaps);
        int budget = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                step();
                check("bubble_count", 32'(fill_count), 32'(cur.size()));
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && budget < 50) begin
            step();
            budget++;
        end
        if (!s_ready) begin
            check("s_ready_timeout", 32'd0, 32'd1);
            s_valid = 1'b0;
            return;
        end
        step();
        s_valid = 1'b0;
        cur.push_back(b);
        if (cur.size() == 24) begin
            sb_q.push_back(model_set(cur));
            cur.delete();
            check("present_valid", 32'(out_valid), 32'd1);
            check("present_count", 32'(fill_count), 32'd24);
            check("present_sready", 32'(s_ready), 32'd0);
        end else begin
            check("fill_count", 32'(fill_count), 32'(cur.size()));
            check("fill_valid", 32'(out_valid), 32'd0);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("consume_valid", 32'(out_valid), 32'd0);
        check("consume_count", 32'(fill_count), 32'd0);
        check("consume_sready", 32'(s_ready), 32'd1);
    endtask

    task automatic check_spec_vecs();
        check("spec_a", a_vec, 32'h08060402);
        check("spec_b", b_vec, 32'h04030201);
        check("spec_c", c_vec, 32'h09070503);
        check("spec_d", d_vec, 32'h08060402);
        check("spec_e", e_vec, 32'h07050301);
        check("spec_f", f_vec, 32'h08060402);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_count"}, 32'(fill_count), 32'd0);
        check({tag, "_sready"}, 32'(s_ready), 32'd1);
        for (int v = 0; v < 6; v++)
            check($sformatf("%s_vec%0d", tag, v), dut_set()[v], 32'd0);
    endtask

    logic [7:0] spec_bytes [24] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                                    8'h03, 8'h05, 8'h07, 8'h09, 8'h02, 8'h04, 8'h06, 8'h08,
                                    8'h01, 8'h03, 8'h05, 8'h07, 8'h02, 8'h04, 8'h06, 8'h08};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held for two cycles
        rst_n = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();
        check_reset_state("post_reset");

        // 2: back-to-back fill with out_ready low, then hold for 10 cycles
        for (int i = 0; i < 24; i++) send(spec_bytes[i], 1'b0);
        check_spec_vecs();
        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (10) begin
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sready", 32'(s_ready), 32'd0);
            check("hold_count", 32'(fill_count), 32'd24);
        end
        s_valid = 1'b0;

        // 3: single-cycle handshake, then a second set starting 03,05,07,09
        consume();
        send(8'h03, 1'b0); send(8'h05, 1'b0); send(8'h07, 1'b0); send(8'h09, 1'b0);
        for (int i = 4; i < 24; i++) send(8'($urandom), 1'b0);
        check("second_a", a_vec, 32'h09070503);
        consume();

        // 4: same set with random bubbles must give identical contents
        for (int i = 0; i < 24; i++) send(spec_bytes[i], 1'b1);
        check_spec_vecs();
        consume();

        // random sets with bubbles
        repeat (3) begin
            for (int i = 0; i < 24; i++) send(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) step();
            consume();
        end

        // 5: clear at fill_count=10 with a byte offered
        for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0);
        check("pre_clear_count", 32'(fill_count), 32'd10);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        step();
        clear   = 1'b0;
        s_valid = 1'b0;
        cur.delete();
        check("clear_count", 32'(fill_count), 32'd0);
        check("clear_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 24; i++) send(8'($urandom), 1'b1);

        // clear while presenting
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_present_valid", 32'(out_valid), 32'd0);
        check("clear_present_count", 32'(fill_count), 32'd0);
        check("clear_present_sready", 32'(s_ready), 32'd1);

        // 6: reset at fill_count=17
        for (int i = 0; i < 17; i++) send(8'($urandom), 1'b0);
        check("pre_reset_count", 32'(fill_count), 32'd17);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        step();
        s_valid = 1'b0;
        check_reset_state("midreset");
        rst_n = 1'b1;
        cur.delete();
        repeat (30) begin
            step();
            check("no_pulse", 32'(out_valid), 32'd0);
        end

        // recovery set after reset
        for (int i = 0; i < 24; i++) send(8'($urandom), 1'b1);
        consume();

        repeat (3) step();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
